axi4_read_burst_sequencer: RTL and testbench

//  Splits one linear read command (start address, beat count) into legal AXI4 INCR bursts on an AR channel.

---
 rtl/axi4_read_burst_sequencer.sv | 143 ++++++++++++++
 tb/tb_axi4_read_burst_sequencer.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/axi4_read_burst_sequencer.sv
// Splits a linear read command into 4KB-safe AXI4 INCR bursts on AR,
// bounds outstanding bursts, watches R for rlast/rresp, reports one status.
// Ports: cmd_* command in, done_* completion out, ar_* AXI AR master,
// r_* monitored R channel (observe only), clk/rst async active-high reset.
module axi4_read_burst_sequencer #(
   parameter int ADDR_WIDTH      = 32,
   parameter int DATA_BYTES      = 4,
   parameter int MAX_BURST       = 16,
   parameter int MAX_OUTSTANDING = 4,
   parameter int COUNT_WIDTH     = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   cmd_valid,
   output logic                   cmd_ready,
   input  logic [ADDR_WIDTH-1:0]  cmd_addr,
   input  logic [COUNT_WIDTH-1:0] cmd_beats,
   input  logic [2:0]             cmd_prot,
   output logic                   done_valid,
   input  logic                   done_ready,
   output logic [1:0]             done_resp,
   output logic                   ar_valid,
   input  logic                   ar_ready,
   output logic [ADDR_WIDTH-1:0]  ar_addr,
   output logic [7:0]             ar_len,
   output logic [2:0]             ar_size,
   output logic [1:0]             ar_burst,
   output logic [3:0]             ar_cache,
   output logic [2:0]             ar_prot,
   input  logic                   r_valid,
   input  logic                   r_ready,
   input  logic                   r_last,
   input  logic [1:0]             r_resp
);

   localparam int SIZE = $clog2(DATA_BYTES);
   localparam int OW   = $clog2(MAX_OUTSTANDING + 1);
   localparam int BW   = (COUNT_WIDTH > 13) ? COUNT_WIDTH : 13;

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

   state_t                 state, state_nxt;
   logic [ADDR_WIDTH-1:0]  addr_q;
   logic [COUNT_WIDTH-1:0] rem_q;
   logic [2:0]             prot_q;
   logic [OW-1:0]          out_q, out_nxt;
   logic [1:0]             resp_q;
   logic                   err_q;
   logic [12:0]            page_bytes;
   logic [BW-1:0]          page_beats, beats;
   logic                   can_issue, ar_fire, r_fire, dec;

   // Burst length: smallest of what is left, MAX_BURST, and room to 4KB.
   always_comb begin
      page_bytes = 13'h1000 - {1'b0, addr_q[11:0]};
      page_beats = BW'(page_bytes >> SIZE);
      beats      = BW'(rem_q);
      if (beats > BW'(MAX_BURST)) beats = BW'(MAX_BURST);
      if (beats > page_beats) beats = page_beats;
   end

   // Outstanding only grows on an AR fire, so once ar_valid rises it
   // cannot fall before ar_ready.
   assign can_issue = (state == ISSUE) &&
                      (out_q < OW'(MAX_OUTSTANDING));
   assign ar_fire   = can_issue & ar_ready;
   assign r_fire    = r_valid & r_ready;
   // A stray rlast with nothing outstanding is dropped.
   assign dec       = r_fire & r_last & (out_q != '0);
   assign out_nxt   = out_q + OW'(ar_fire) - OW'(dec);

   assign ar_valid  = can_issue;
   assign ar_addr   = addr_q;
   assign ar_prot   = prot_q;
   assign ar_size   = 3'(SIZE);
   assign ar_burst  = 2'b01;
   assign ar_cache  = 4'b0011;
   assign done_resp = resp_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      cmd_ready  = 1'b0;
      done_valid = 1'b0;
      ar_len     = 8'd0;
      unique case (state)
         IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid)
               state_nxt = (cmd_beats == '0) ? DONE : ISSUE;
         end
         ISSUE: begin
            ar_len = 8'(beats - BW'(1));
            if (ar_fire && rem_q == COUNT_WIDTH'(beats))
               state_nxt = DRAIN;
         end
         // Look at the next count so the last rlast reaches DONE in 1 cycle.
         DRAIN: begin
            if (out_nxt == '0) state_nxt = DONE;
         end
         DONE: begin
            done_valid = 1'b1;
            if (done_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_q <= '0;
         rem_q  <= '0;
         prot_q <= '0;
         out_q  <= '0;
         resp_q <= 2'b00;
         err_q  <= 1'b0;
      end else begin
         out_q <= out_nxt;
         if (state == IDLE && cmd_valid) begin
            addr_q <= cmd_addr;
            rem_q  <= cmd_beats;
            prot_q <= cmd_prot;
            resp_q <= 2'b00;
            err_q  <= 1'b0;
         end
         if (ar_fire) begin
            addr_q <= addr_q + (ADDR_WIDTH'(beats) << SIZE);
            rem_q  <= rem_q - COUNT_WIDTH'(beats);
         end
         // First error response wins.
         if ((state == ISSUE || state == DRAIN) && r_fire &&
             r_resp != 2'b00 && !err_q) begin
            resp_q <= r_resp;
            err_q  <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_axi4_read_burst_sequencer.sv
// Directed bench for axi4_read_burst_sequencer.
// Drives and samples on the falling edge; DUT state moves on the rising edge.
module tb_axi4_read_burst_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid, cmd_ready;
   logic [31:0] cmd_addr;
   logic [15:0] cmd_beats;
   logic [2:0]  cmd_prot;
   logic        done_valid, done_ready;
   logic [1:0]  done_resp;
   logic        ar_valid, ar_ready;
   logic [31:0] ar_addr;
   logic [7:0]  ar_len;
   logic [2:0]  ar_size;
   logic [1:0]  ar_burst;
   logic [3:0]  ar_cache;
   logic [2:0]  ar_prot;
   logic        r_valid, r_ready, r_last;
   logic [1:0]  r_resp;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   axi4_read_burst_sequencer dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_addr(cmd_addr), .cmd_beats(cmd_beats), .cmd_prot(cmd_prot),
      .done_valid(done_valid), .done_ready(done_ready),
      .done_resp(done_resp),
      .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr),
      .ar_len(ar_len), .ar_size(ar_size), .ar_burst(ar_burst),
      .ar_cache(ar_cache), .ar_prot(ar_prot),
      .r_valid(r_valid), .r_ready(r_ready), .r_last(r_last),
      .r_resp(r_resp)
   );

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic issue_cmd(input logic [31:0] a, input logic [15:0] b);
      cmd_valid = 1'b1;
      cmd_addr  = a;
      cmd_beats = b;
      cmd_prot  = 3'b010;
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic r_beat(input logic last, input logic [1:0] resp);
      r_valid = 1'b1;
      r_ready = 1'b1;
      r_last  = last;
      r_resp  = resp;
      @(negedge clk);
      r_valid = 1'b0;
      r_last  = 1'b0;
      r_resp  = 2'b00;
   endtask

   task automatic consume_done();
      done_ready = 1'b1;
      @(negedge clk);
      done_ready = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      cmd_valid = 1'b0; cmd_addr = '0; cmd_beats = '0; cmd_prot = '0;
      done_ready = 1'b0; ar_ready = 1'b0;
      r_valid = 1'b0; r_ready = 1'b0; r_last = 1'b0; r_resp = 2'b00;
      repeat (2) @(negedge clk);
      chk("rst_cmd_ready", cmd_ready, 1);
      chk("rst_ar_valid", ar_valid, 0);
      chk("rst_done_valid", done_valid, 0);
      chk("rst_ar_addr", ar_addr, 0);
      chk("rst_ar_len", ar_len, 0);
      chk("rst_ar_prot", ar_prot, 0);
      chk("rst_done_resp", done_resp, 0);
      rst = 1'b0;
      @(negedge clk);

      // 40 beats from 0x1000: 16 + 16 + 8
      ar_ready = 1'b1;
      issue_cmd(32'h1000, 16'd40);
      chk("t1_cmd_ready", cmd_ready, 0);
      chk("t1_b0_valid", ar_valid, 1);
      chk("t1_b0_addr", ar_addr, 32'h1000);
      chk("t1_b0_len", ar_len, 15);
      chk("t1_prot", ar_prot, 3'b010);
      chk("t1_size", ar_size, 2);
      chk("t1_burst", ar_burst, 1);
      chk("t1_cache", ar_cache, 4'b0011);
      @(negedge clk);
      chk("t1_b1_addr", ar_addr, 32'h1040);
      chk("t1_b1_len", ar_len, 15);
      @(negedge clk);
      chk("t1_b2_addr", ar_addr, 32'h1080);
      chk("t1_b2_len", ar_len, 7);
      @(negedge clk);
      chk("t1_drain_valid", ar_valid, 0);
      r_beat(1'b1, 2'b00);
      r_beat(1'b1, 2'b00);
      chk("t1_not_done", done_valid, 0);
      r_beat(1'b1, 2'b00);
      chk("t1_done_valid", done_valid, 1);
      chk("t1_done_resp", done_resp, 0);
      consume_done();
      chk("t1_idle_ready", cmd_ready, 1);
      chk("t1_idle_done", done_valid, 0);

      // 10 beats from 0x1FF0: 4 to the page edge, then 6
      issue_cmd(32'h1FF0, 16'd10);
      chk("t2_b0_addr", ar_addr, 32'h1FF0);
      chk("t2_b0_len", ar_len, 3);
      @(negedge clk);
      chk("t2_b1_addr", ar_addr, 32'h2000);
      chk("t2_b1_len", ar_len, 5);
      @(negedge clk);
      chk("t2_drain_valid", ar_valid, 0);
      r_beat(1'b1, 2'b00);
      r_beat(1'b1, 2'b00);
      chk("t2_done_valid", done_valid, 1);
      consume_done();

      // 128 beats with no R traffic: window of 4 bursts
      issue_cmd(32'h0, 16'd128);
      for (int i = 0; i < 4; i++) begin
         chk("t3_win_valid", ar_valid, 1);
         chk("t3_win_addr", ar_addr, 64'(i * 64));
         @(negedge clk);
      end
      chk("t3_full_valid", ar_valid, 0);
      @(negedge clk);
      chk("t3_full_valid2", ar_valid, 0);
      ar_ready = 1'b0;
      r_beat(1'b1, 2'b00);
      chk("t3_b4_valid", ar_valid, 1);
      chk("t3_b4_addr", ar_addr, 32'h100);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("t4_hold_valid", ar_valid, 1);
         chk("t4_hold_addr", ar_addr, 32'h100);
         chk("t4_hold_len", ar_len, 15);
      end
      // AR fire together with rlast: window stays at 3 of 4
      ar_ready = 1'b1;
      r_beat(1'b1, 2'b00);
      chk("t4_sim_valid", ar_valid, 1);
      chk("t4_sim_addr", ar_addr, 32'h140);
      @(negedge clk);
      chk("t4_full_again", ar_valid, 0);

      // async reset while ISSUE is active
      #2 rst = 1'b1;
      #1;
      chk("t7_rst_ar_valid", ar_valid, 0);
      chk("t7_rst_cmd_ready", cmd_ready, 1);
      chk("t7_rst_ar_addr", ar_addr, 0);
      chk("t7_rst_ar_len", ar_len, 0);
      chk("t7_rst_done", done_valid, 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // error responses: SLVERR in burst 2, DECERR in burst 3
      issue_cmd(32'h1000, 16'd40);
      repeat (3) @(negedge clk);
      chk("t5_drain_valid", ar_valid, 0);
      r_beat(1'b1, 2'b00);
      r_beat(1'b0, 2'b10);
      r_beat(1'b1, 2'b00);
      r_beat(1'b1, 2'b11);
      chk("t5_done_valid", done_valid, 1);
      chk("t5_done_resp", done_resp, 2'b10);
      repeat (3) @(negedge clk);
      chk("t5_hold_valid", done_valid, 1);
      chk("t5_hold_resp", done_resp, 2'b10);
      consume_done();
      chk("t5_idle", cmd_ready, 1);

      // zero-beat command
      issue_cmd(32'h3000, 16'd0);
      chk("t6_done_valid", done_valid, 1);
      chk("t6_no_ar", ar_valid, 0);
      chk("t6_resp", done_resp, 0);
      consume_done();
      chk("t6_idle", cmd_ready, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
